// File: rtl/pc_npc_unit.sv
// SPARC V8 PC/nPC stage: delayed transfer, annul, trap entry.
// Optional retired-instruction counter: define PCU_RETIRE_CNT_EN.
module pc_npc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  input  logic        xfer,
  input  logic [31:0] target,
  input  logic        annul,
  input  logic        trap,
  input  logic [31:0] trap_vec,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic [1:0]  npc_sel,
  output logic        slot_valid,
  output logic        trap_ack,
  output logic        error_mode,
  output logic [31:0] retire_cnt
);

  typedef enum logic [1:0] {
    S_RESET,
    S_RUN,
    S_TRAP,
    S_ERROR
  } state_t;

  state_t state;

  logic [31:0] tgt_a;
  logic [31:0] tv_a;
  logic [31:0] npc_inc;
  logic        run_adv;

  assign tgt_a   = {target[31:2], 2'b00};
  assign tv_a    = {trap_vec[31:2], 2'b00};
  assign npc_inc = npc + 32'd4;
  assign run_adv = (state == S_RUN) && advance;

  // Annulled slots bypass trap/xfer decode entirely.
  always_comb begin
    npc_sel = 2'b11;
    if (run_adv) begin
      unique case (1'b1)
        !slot_valid:                 npc_sel = 2'b00;
        slot_valid && trap:          npc_sel = 2'b10;
        slot_valid && !trap && xfer: npc_sel = 2'b01;
        default:                     npc_sel = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RESET;
      pc         <= RESET_PC;
      npc        <= RESET_PC + 32'd4;
      slot_valid <= 1'b0;
      trap_ack   <= 1'b0;
      error_mode <= 1'b0;
    end else begin
      trap_ack <= 1'b0;
      unique case (state)
        S_RESET: begin
          state      <= S_RUN;
          slot_valid <= 1'b1;
        end
        S_RUN: begin
          unique case (npc_sel)
            2'b00: begin
              pc         <= npc;
              npc        <= npc_inc;
              slot_valid <= ~(slot_valid & annul);
            end
            2'b01: begin
              pc         <= npc;
              npc        <= tgt_a;
              slot_valid <= ~annul;
            end
            2'b10: begin
              pc         <= tv_a;
              npc        <= tv_a + 32'd4;
              slot_valid <= 1'b1;
              trap_ack   <= 1'b1;
              state      <= S_TRAP;
            end
            default: ;
          endcase
        end
        S_TRAP: begin
          if (trap) begin
            state      <= S_ERROR;
            error_mode <= 1'b1;
          end else begin
            state <= S_RUN;
          end
        end
        S_ERROR: ;
        default: state <= S_ERROR;
      endcase
    end
  end

`ifdef PCU_RETIRE_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (run_adv && slot_valid) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign retire_cnt = cnt_q;
`else
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_npc_unit.sv
// Scoreboarded random/directed bench for pc_npc_unit.
// Reference model tracks the architectural PC/nPC pair directly.
module tb_pc_npc_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_TRAP = 2;
  localparam int M_HALT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        advance = 1'b0;
  logic        xfer = 1'b0;
  logic [31:0] target = '0;
  logic        annul = 1'b0;
  logic        trap = 1'b0;
  logic [31:0] trap_vec = '0;
  logic [31:0] pc;
  logic [31:0] npc;
  logic [1:0]  npc_sel;
  logic        slot_valid;
  logic        trap_ack;
  logic        error_mode;
  logic [31:0] retire_cnt;

  pc_npc_unit #(.RESET_PC(RPC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .advance(advance),
    .xfer(xfer),
    .target(target),
    .annul(annul),
    .trap(trap),
    .trap_vec(trap_vec),
    .pc(pc),
    .npc(npc),
    .npc_sel(npc_sel),
    .slot_valid(slot_valid),
    .trap_ack(trap_ack),
    .error_mode(error_mode),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [1:0]  sel;
    logic        sv;
    logic        ack;
    logic        err;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_npc;
  logic        m_sv;
  logic        m_ack;
  logic        m_err;
  logic [31:0] m_cnt;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("pc", pc, e.pc);
      check("npc", npc, e.npc);
      check("npc_sel", {30'd0, npc_sel}, {30'd0, e.sel});
      check("slot_valid", {31'd0, slot_valid}, {31'd0, e.sv});
      check("trap_ack", {31'd0, trap_ack}, {31'd0, e.ack});
      check("error_mode", {31'd0, error_mode}, {31'd0, e.err});
      check("retire_cnt", retire_cnt, e.cnt);
    end
  end

  function automatic logic [31:0] algn(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  // Called at posedge+1; returns at the following posedge+1.
  task automatic step(input bit adv, input bit x, input logic [31:0] tgt,
                      input bit an, input bit tr, input logic [31:0] tv);
    exp_t e;
    bit live;
    advance  = adv;
    xfer     = x;
    target   = tgt;
    annul    = an;
    trap     = tr;
    trap_vec = tv;
    live = (m_mode == M_RUN) && adv;
    e.pc  = m_pc;
    e.npc = m_npc;
    e.sv  = m_sv;
    e.ack = m_ack;
    e.err = m_err;
    e.cnt = m_cnt;
    if (!live) e.sel = 2'b11;
    else if (!m_sv) e.sel = 2'b00;
    else if (tr) e.sel = 2'b10;
    else if (x) e.sel = 2'b01;
    else e.sel = 2'b00;
    q.push_back(e);
    m_ack = 1'b0;
    if (m_mode == M_TRAP) begin
      m_mode = tr ? M_HALT : M_RUN;
      m_err  = tr;
    end else if (live) begin
`ifdef PCU_RETIRE_CNT_EN
      if (m_sv) m_cnt = m_cnt + 1;
`endif
      if (!m_sv) begin
        m_pc  = m_npc;
        m_npc = m_npc + 4;
        m_sv  = 1'b1;
      end else if (tr) begin
        m_pc   = algn(tv);
        m_npc  = algn(tv) + 4;
        m_ack  = 1'b1;
        m_mode = M_TRAP;
      end else begin
        m_pc  = m_npc;
        m_npc = x ? algn(tgt) : m_npc + 4;
        m_sv  = !an;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Asserted between edges; state must clear with no clock.
  task automatic do_reset();
    rst_n   = 1'b0;
    advance = 1'b1;
    xfer    = 1'b0;
    trap    = 1'b0;
    #1;
    check("rst_pc", pc, RPC);
    check("rst_npc", npc, RPC + 4);
    check("rst_sv", {31'd0, slot_valid}, 32'd0);
    check("rst_err", {31'd0, error_mode}, 32'd0);
    check("rst_cnt", retire_cnt, 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_mode = M_RUN;
    m_pc   = RPC;
    m_npc  = RPC + 4;
    m_sv   = 1'b1;
    m_ack  = 1'b0;
    m_err  = 1'b0;
    m_cnt  = '0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    repeat (3) step(1, 0, 0, 0, 0, 0);
    // delayed branch at pc=8
    do_reset();
    repeat (2) step(1, 0, 0, 0, 0, 0);
    step(1, 1, 32'h100, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h44, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    // annulled slot ignores trap/xfer
    do_reset();
    repeat (2) step(1, 0, 0, 0, 0, 0);
    step(1, 1, 32'h200, 1, 0, 0);
    step(1, 1, 32'h300, 1, 1, 32'h900);
    step(1, 0, 0, 0, 0, 0);
    // trap entry, then trap while in trap -> error
    do_reset();
    repeat (4) step(1, 0, 0, 0, 0, 0);
    step(1, 1, 32'h500, 0, 1, 32'h0000_0803);
    step(1, 0, 0, 0, 1, 32'h0000_0A00);
    repeat (10) step(1, 1, $urandom, 0, 1, $urandom);
    // trap then clean return
    do_reset();
    step(1, 0, 0, 0, 1, 32'h0000_1002);
    step(1, 0, 0, 0, 0, 0);
    repeat (2) step(1, 0, 0, 1, 0, 0);
    // wrap at top of address space
    do_reset();
    step(1, 1, 32'hFFFF_FFFB, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0, 0);
    // random phase with periodic resets
    for (int i = 0; i < 600; i++) begin
      logic [31:0] t;
      if (i % 75 == 0) do_reset();
      t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 | $urandom_range(0, 15)
                                      : $urandom;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, t,
           $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, $urandom);
    end
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d left expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_npc_unit.md
Name: pc_npc_unit

Overview:
- Program-counter stage of the SPARC V8 datapath. Holds the architectural PC/nPC pair and implements delayed control transfer, delay-slot annulment and trap-vector entry.
- Produces the 2-bit select that drives the 32-bit 4x1 next-address multiplexer, and registers the chosen address.
- Sits upstream of instruction fetch and downstream of branch/trap resolution in the control unit.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; nPC resets to RESET_PC+4.

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
advance  input  1  current instruction retires this cycle; PC/nPC update
xfer  input  1  current instruction is a taken delayed control transfer (Bicc/CALL/JMPL)
target  input  32  transfer target address
annul  input  1  annul the next (delay-slot) instruction
trap  input  1  trap request for the current instruction
trap_vec  input  32  trap vector address (TBR-formed)
pc  output  32  current PC
npc  output  32  current nPC
npc_sel  output  2  next-address mux select: 00 npc+4, 01 target, 10 trap_vec, 11 hold
slot_valid  output  1  instruction at pc is live (not annulled)
trap_ack  output  1  one-cycle pulse on trap entry
error_mode  output  1  processor halted in error mode
retire_cnt  output  32  retired-instruction count (see Optional Feature)

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - pc=RESET_PC, npc=RESET_PC+4.
  - state=S_RESET, slot_valid=0, trap_ack=0, error_mode=0, retire_cnt=0.
- FSM states: S_RESET, S_RUN, S_TRAP, S_ERROR.
- S_RESET:
  - First rising edge after rst_n deasserts moves to S_RUN and sets slot_valid=1.
  - PC/nPC are unchanged; advance is ignored.
- S_RUN, advance=0: all registers hold; npc_sel=11.
- S_RUN, advance=1, slot_valid=0 (annulled instruction): xfer, trap and annul are ignored.
  - pc<=npc, npc<=npc+4, slot_valid<=1, npc_sel=00.
- S_RUN, advance=1, slot_valid=1, priority trap > xfer > sequential:
  - trap: pc<=trap_vec, npc<=trap_vec+4, slot_valid<=1, trap_ack<=1, state<=S_TRAP, npc_sel=10. xfer and annul are ignored.
  - xfer: pc<=npc, npc<=target, slot_valid<=~annul, npc_sel=01.
  - otherwise: pc<=npc, npc<=npc+4, slot_valid<=~annul, npc_sel=00.
- S_TRAP:
  - Lasts exactly one cycle. trap_ack=1 for that cycle, 0 otherwise.
  - Next edge returns to S_RUN regardless of advance; PC/nPC hold; npc_sel=11.
  - trap=1 in S_TRAP (trap with traps disabled) -> S_ERROR.
- S_ERROR:
  - error_mode=1; PC/nPC frozen; npc_sel=11; all inputs ignored.
  - Only rst_n exits this state.
- Arithmetic:
  - +4 is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 32'h0000_0000.
  - target[1:0] and trap_vec[1:0] are cleared on load, so pc[1:0] and npc[1:0] are always 00.
- npc_sel is combinational from state, advance, slot_valid, trap and xfer. It is valid in the same cycle as those inputs.
- Reset asserted mid-transfer discards any pending delay-slot or annul state.

Optional Feature:
Macro PCU_RETIRE_CNT_EN.
- Defined:
  - retire_cnt increments by 1 on each S_RUN edge with advance=1 and slot_valid=1, including a trapping instruction.
  - Annulled instructions are not counted.
  - Wraps modulo 2^32; cleared by reset; frozen in S_ERROR.
- Undefined: retire_cnt is tied to 32'h0 and no counter logic is synthesized.

Test Plan:
- Reset/start: RESET_PC=0, release rst_n, advance=1 for 3 cycles -> after S_RESET cycle, pc/npc step 0/4 -> 4/8 -> 8/C -> C/10; npc_sel=00; slot_valid=1.
- Delayed branch: at pc=8, npc=C, xfer=1, target=0x100, annul=0, advance=1 -> pc=C, npc=0x100; next advance -> pc=0x100, npc=0x104.
- Annulled delay slot: at pc=8, xfer=1, target=0x200, annul=1 -> slot_valid=0 at pc=C. Asserting trap=1 and xfer=1 there is ignored -> next pc=0x200, npc=0x204, slot_valid=1.
- Trap entry and error: trap=1, trap_vec=0x0000_0803 at pc=0x10 -> pc=0x800, npc=0x804, trap_ack high 1 cycle, npc_sel=10. trap=1 again during S_TRAP -> error_mode=1, pc stays 0x800 for 10 cycles with advance=1.
- Wrap and mid-operation reset: npc=0xFFFF_FFFC, advance -> npc=0x0000_0000. Then assert rst_n=0 between edges -> pc=0, npc=4 immediately, with no clock edge.
- PCU_RETIRE_CNT_EN: 5 advances, one of them annulled -> retire_cnt=4. Without the macro, retire_cnt=0 throughout.
